modn_count_monitor: RTL

//  Receive-side checker for the mod-N counter interface (count + modN).

---
 rtl/modn_count_monitor.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/modn_count_monitor.sv
// modn_count_monitor: receive-side checker for a mod-N counter.
// Predicts each sampled count from the live modN. It flags sequence errors,
// resynchronises after an error, and keeps a saturating count of wraps.
// Optional feature: define MODN_MON_ERRCNT_EN to add a saturating err_cnt
// register. Without it, err_cnt is tied to zero.
module modn_count_monitor #(
    parameter int W        = 6,
    parameter int WRAPW    = 8,
    parameter int ERRW     = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     modN,
    input  logic [W-1:0]     count,
    input  logic             smp,
    output logic             locked,
    output logic             err,
    output logic             err_sticky,
    output logic             wrap,
    output logic [WRAPW-1:0] wrap_cnt,
    output logic [W-1:0]     expected,
    output logic [ERRW-1:0]  err_cnt
);

    localparam int RUNW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      expected_q, expected_d;
    logic [RUNW-1:0]   run_q, run_d;
    logic              err_q, err_d;
    logic              wrap_q, wrap_d;
    logic              sticky_q, sticky_d;
    logic [WRAPW-1:0]  wrap_cnt_q, wrap_cnt_d;

    logic [W-1:0]      nxt_val;
    logic              nxt_wrap;

    // Successor of the sampled count under the live modulus.
    // modN-1 is only evaluated once modN >= 2 is known.
    always_comb begin
        nxt_val  = '0;
        nxt_wrap = 1'b0;
        if (modN <= W'(1)) begin
            nxt_wrap = 1'b1;
        end else if (count >= modN - 1'b1) begin
            nxt_wrap = 1'b1;
        end else begin
            nxt_val = count + 1'b1;
        end
    end

    // Tracking FSM: next state, prediction, pulses and wrap counter.
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        run_d      = run_q;
        err_d      = 1'b0;
        wrap_d     = 1'b0;
        sticky_d   = sticky_q;
        wrap_cnt_d = wrap_cnt_q;
        if (smp) begin
            case (state_q)
                ACQ: begin
                    expected_d = nxt_val;
                    run_d      = '0;
                    state_d    = TRACK;
                end
                TRACK: begin
                    expected_d = nxt_val;
                    if (count == expected_q) begin
                        wrap_d = nxt_wrap;
                    end else begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                        run_d    = '0;
                        state_d  = RESYNC;
                    end
                end
                RESYNC: begin
                    // A mismatch re-seeds the prediction from the sample.
                    // It does not raise another err pulse.
                    expected_d = nxt_val;
                    if (count == expected_q) begin
                        if (run_q == RUNW'(LOCK_CNT - 1)) begin
                            run_d   = '0;
                            state_d = TRACK;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                default: begin
                    state_d = ACQ;
                end
            endcase
        end
        if (wrap_d && (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACQ;
            expected_q <= '0;
            run_q      <= '0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
            sticky_q   <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            run_q      <= run_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
            sticky_q   <= sticky_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign locked     = (state_q == TRACK);
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign wrap       = wrap_q;
    assign wrap_cnt   = wrap_cnt_q;
    assign expected   = expected_q;

`ifdef MODN_MON_ERRCNT_EN
    logic [ERRW-1:0] err_cnt_q, err_cnt_d;

    // Saturating tally of err pulses.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
